control_unit_pipe: RTL and testbench

CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

---
 rtl/control_unit_pipe.sv | 151 +++++++++++++++
 tb/tb_control_unit_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pipe.sv
// Single-issue control unit: decodes {op,funct} into a registered control word
// with stall/flush handling, debug single-stepping and a HALT drain sequence.
`timescale 1ns/1ps
module control_unit_pipe #(
  parameter int                     NB_FUNCTION  = 6,
  parameter int                     NB_CONTROL   = 18,
  parameter int                     NB_COUNT     = 32,
  parameter int                     DRAIN_CYCLES = 4,
  parameter logic [NB_FUNCTION-1:0] HALT_OPCODE  = NB_FUNCTION'(6'b111111)
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_instr_valid,
  input  logic [NB_FUNCTION-1:0] i_operation,
  input  logic [NB_FUNCTION-1:0] i_function,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_step_mode,
  input  logic                   i_step,
  output logic [NB_CONTROL-1:0]  o_control,
  output logic                   o_control_valid,
  output logic                   o_ready,
  output logic [1:0]             o_state,
  output logic                   o_halted,
  output logic [NB_COUNT-1:0]    o_instr_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  // Control word layout, MSB first: RegDst MemToReg MemRead Branch MemWrite
  // Ope2..0 ALUSrc RegWrite ShiftSrc JmpSrc JReturnDst EQorNE DataMask1..0
  // IsUnsigned JmpOrBrch.
  function automatic logic [17:0] decode_ctrl(input logic [5:0] op,
                                              input logic [5:0] fn);
    logic [17:0] w;
    w = {10'b0000000101, ~(fn[5] | fn[2]), 7'b0001100};
    casez (op)
      6'b1?0???: w = {14'b11100000110000, op[1], op[0], op[2], 1'b0};
      6'b1?1???: w = {14'b00001000100000, op[1], op[0], op[2], 1'b0};
      6'b0?1???: w = {5'b10000, op[2], op[1], op[0], 10'b1100001100};
      6'b0?01??: w = {13'b0001000000010, op[0], 4'b1100};
      6'b0?001?: w = {9'b000000000, op[0], 2'b01, op[0], 5'b01101};
      6'b0?000?: begin
        if (fn ==? 6'b0?1???) w = {9'b000000000, fn[0], 8'b00001101};
      end
      default: ;
    endcase
    return w;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              drain_q, drain_d;
  logic                    step_q;
  logic [NB_CONTROL-1:0]   ctrl_q, ctrl_d;
  logic                    vld_q, vld_d;
  logic [NB_COUNT-1:0]     cnt_q, cnt_d;

  logic                    step_pulse;
  logic                    issue_gate;
  logic                    issue;
  logic                    is_halt;
  logic                    halt_issue;
  logic                    vld_p0;
  logic [NB_CONTROL-1:0]   ctrl_p0;

  // A step request only counts on the cycle i_step rises, so a held pulse
  // cannot issue a burst of instructions.
  assign step_pulse = i_step & ~step_q;
  assign issue_gate = ~i_stall & ~i_flush &
                      (((state_q == RUN) & ~i_step_mode) |
                       ((state_q == STEP_WAIT) & step_pulse));
  assign issue      = i_instr_valid & issue_gate;
  assign is_halt    = (i_operation == HALT_OPCODE);
  assign halt_issue = issue & is_halt;

  // Stage p0: decode of the instruction being issued this cycle
  assign vld_p0  = issue & ~is_halt;
  assign ctrl_p0 = NB_CONTROL'(decode_ctrl(i_operation[5:0], i_function[5:0]));

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN, STEP_WAIT: begin
        if (halt_issue) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (i_step_mode) begin
          state_d = STEP_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) state_d = HALTED;
        else                 drain_d = drain_q - 4'd1;
      end
      HALTED:  ;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (vld_p0) begin
      ctrl_d = ctrl_p0;
      vld_d  = 1'b1;
      if (~&cnt_q) cnt_d = cnt_q + NB_COUNT'(1);
    end else if (~(i_stall & ~i_flush)) begin
      // Any non-issue cycle that is not a pure stall inserts a bubble.
      ctrl_d = '0;
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= RUN;
      drain_q <= 4'd0;
      step_q  <= 1'b0;
      ctrl_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      step_q  <= i_step;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p1: registered outputs
  assign o_control       = ctrl_q;
  assign o_control_valid = vld_q;
  assign o_ready         = issue_gate;
  assign o_state         = state_q;
  assign o_halted        = (state_q == HALTED);
  assign o_instr_count   = cnt_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_control_unit_pipe;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  fn = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;

  logic [17:0] ctrl;
  logic        cvld;
  logic        ready;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] count;

  logic [17:0] s_ctrl;
  logic        s_cvld;
  logic        s_ready;
  logic [1:0]  s_state;
  logic        s_halted;
  logic [3:0]  s_count;

  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model state
  logic [17:0] m_ctrl;
  logic        m_vld;
  int unsigned m_cnt;
  int unsigned m_scnt;
  logic        m_step_mode_seen;
  logic        m_prev_step;
  int          m_halt_cyc;
  int          m_cyc;

  always #5 clk = ~clk;

  control_unit_pipe #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_instr_valid(valid),
    .i_operation(op), .i_function(fn), .i_stall(stall), .i_flush(flush),
    .i_step_mode(step_mode), .i_step(step),
    .o_control(ctrl), .o_control_valid(cvld), .o_ready(ready),
    .o_state(state), .o_halted(halted), .o_instr_count(count)
  );

  control_unit_pipe #(.DRAIN_CYCLES(DRAIN), .NB_COUNT(4)) dut_sat (
    .i_clock(clk), .i_reset_n(rst_n), .i_instr_valid(valid),
    .i_operation(op), .i_function(fn), .i_stall(stall), .i_flush(flush),
    .i_step_mode(step_mode), .i_step(step),
    .o_control(s_ctrl), .o_control_valid(s_cvld), .o_ready(s_ready),
    .o_state(s_state), .o_halted(s_halted), .o_instr_count(s_count)
  );

  // Reference decode built from the opcode-class table as masked compares.
  function automatic logic [17:0] ref_dec(input logic [5:0] o, input logic [5:0] f);
    int w;
    if ((o & 6'h28) == 6'h20)
      w = 'h38300 | (int'(o[1]) << 3) | (int'(o[0]) << 2) | (int'(o[2]) << 1);
    else if ((o & 6'h28) == 6'h28)
      w = 'h02200 | (int'(o[1]) << 3) | (int'(o[0]) << 2) | (int'(o[2]) << 1);
    else if ((o & 6'h28) == 6'h08)
      w = 'h2030C | (int'(o[2]) << 12) | (int'(o[1]) << 11) | (int'(o[0]) << 10);
    else if ((o & 6'h2C) == 6'h04)
      w = 'h0404C | (int'(o[0]) << 4);
    else if ((o & 6'h2E) == 6'h02)
      w = 'h0004D | (o[0] ? 'h120 : 0);
    else if ((f & 6'h28) == 6'h08)
      w = 'h0000D | (int'(f[0]) << 8);
    else
      w = 'h0050C | ((f[5] | f[2]) ? 0 : 'h80);
    return 18'(w);
  endfunction

  function automatic int m_state();
    if (m_halt_cyc >= 0) return (m_cyc - m_halt_cyc <= DRAIN) ? 2 : 3;
    return m_step_mode_seen ? 1 : 0;
  endfunction

  function automatic logic m_ready();
    int st;
    st = m_state();
    return !stall && !flush &&
           ((st == 0 && !step_mode) || (st == 1 && step && !m_prev_step));
  endfunction

  function automatic void model_reset();
    m_ctrl = '0;
    m_vld = 1'b0;
    m_cnt = 0;
    m_scnt = 0;
    m_step_mode_seen = 1'b0;
    m_prev_step = 1'b0;
    m_halt_cyc = -1;
    m_cyc = 0;
  endfunction

  // Advance model and DUT by one clock, leaving time at posedge+1.
  task automatic tick();
    int st;
    logic iss, hlt;
    st = m_state();
    iss = valid && m_ready();
    hlt = (op == 6'h3F);
    if (iss && !hlt) begin
      m_ctrl = ref_dec(op, fn);
      m_vld = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_scnt < 15) m_scnt++;
    end else if (!(stall && !flush)) begin
      m_ctrl = '0;
      m_vld = 1'b0;
    end
    if (st < 2) begin
      if (iss && hlt) m_halt_cyc = m_cyc;
      else m_step_mode_seen = step_mode;
    end
    m_prev_step = step;
    @(posedge clk);
    #1;
    m_cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 0; op = '0; fn = '0; stall = 0; flush = 0; step_mode = 0; step = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    valid = 1'b1; op = 6'h00; fn = 6'h20;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 18'h0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
    n_cmp++; if (cvld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", cvld); end
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_cmp++; if (count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = 1'b0;
  endtask

  task automatic test_lw();
    do_reset();
    valid = 1'b1; op = 6'b100011; fn = 6'($urandom_range(0, 63));
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready got=%b exp=1", ready); end
    tick();
    valid = 1'b0;
    n_cmp++; if (ctrl !== 18'h3830C) begin n_fail++; $display("FAIL lw_ctrl got=%h exp=3830c", ctrl); end
    n_cmp++; if (cvld !== 1'b1) begin n_fail++; $display("FAIL lw_vld got=%b exp=1", cvld); end
    n_cmp++; if (count !== 32'd1) begin n_fail++; $display("FAIL lw_count got=%0d exp=1", count); end
    tick();
    n_cmp++; if (cvld !== 1'b0 || ctrl !== 18'h0) begin n_fail++; $display("FAIL lw_bubble got=%b/%h exp=0/0", cvld, ctrl); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    valid = 1'b1; op = 6'b000000; fn = 6'b100000;
    tick();
    op = 6'b101011; fn = 6'($urandom_range(0, 63));
    n_cmp++; if (ctrl !== 18'h0050C || cvld !== 1'b1) begin n_fail++; $display("FAIL b2b_add got=%h/%b exp=0050c/1", ctrl, cvld); end
    tick();
    valid = 1'b0;
    n_cmp++; if (ctrl !== 18'h0220C || cvld !== 1'b1) begin n_fail++; $display("FAIL b2b_sw got=%h/%b exp=0220c/1", ctrl, cvld); end
    n_cmp++; if (count !== 32'd2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", count); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    valid = 1'b1; op = 6'b000100; fn = '0;
    tick();
    n_cmp++; if (ctrl !== 18'h0404C || cvld !== 1'b1) begin n_fail++; $display("FAIL beq_ctrl got=%h/%b exp=0404c/1", ctrl, cvld); end
    stall = 1'b1; op = 6'b000000; fn = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, ready); end
      tick();
      n_cmp++; if (ctrl !== 18'h0404C || cvld !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=0404c/1", i, ctrl, cvld); end
      n_cmp++; if (count !== 32'd1) begin n_fail++; $display("FAIL stall_count cyc=%0d got=%0d exp=1", i, count); end
    end
    flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0; valid = 1'b0;
    n_cmp++; if (ctrl !== 18'h0 || cvld !== 1'b0) begin n_fail++; $display("FAIL flush_bubble got=%h/%b exp=0/0", ctrl, cvld); end
    n_cmp++; if (count !== 32'd1) begin n_fail++; $display("FAIL flush_count got=%0d exp=1", count); end
  endtask

  task automatic test_step();
    int n_iss;
    n_iss = 0;
    do_reset();
    step_mode = 1'b1; valid = 1'b1; op = 6'b000000; fn = 6'b100000;
    for (int c = 0; c < 12; c++) begin
      step = ((c >= 2 && c <= 4) || c == 8);
      tick();
      if (cvld === 1'b1) n_iss++;
    end
    step = 1'b0;
    tick();
    n_cmp++; if (n_iss != 2) begin n_fail++; $display("FAIL step_issues got=%0d exp=2", n_iss); end
    n_cmp++; if (count !== 32'd2) begin n_fail++; $display("FAIL step_count got=%0d exp=2", count); end
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL step_state got=%0d exp=1", state); end
    valid = 1'b0; step_mode = 1'b0;
  endtask

  task automatic test_halt();
    // Reset part-way through the drain.
    do_reset();
    valid = 1'b1; op = 6'h3F;
    tick();
    valid = 1'b0; op = '0;
    tick();
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL halt_abort_pre got=%0d exp=2", state); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0 || ctrl !== 18'h0 || cvld !== 1'b0 || halted !== 1'b0 || count !== 32'd0) begin
      n_fail++; $display("FAIL halt_abort state=%0d ctrl=%h vld=%b halted=%b cnt=%0d exp=all 0", state, ctrl, cvld, halted, count);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Full drain into HALTED, with traffic that must be ignored.
    do_reset();
    valid = 1'b1; op = 6'b000000; fn = 6'b100000;
    tick();
    op = 6'h3F;
    tick();
    op = 6'b000000;
    for (int i = 1; i <= DRAIN; i++) begin
      n_cmp++; if (state !== 2'd2 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_drain N+%0d state=%0d halted=%b exp=2/0", i, state, halted); end
      n_cmp++; if (cvld !== 1'b0 || count !== 32'd1) begin n_fail++; $display("FAIL halt_drain_out N+%0d vld=%b cnt=%0d exp=0/1", i, cvld, count); end
      stall = ($urandom_range(0, 1) == 1);
      tick();
    end
    n_cmp++; if (halted !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL halt_final halted=%b state=%0d exp=1/3", halted, state); end
    stall = 1'b0; step_mode = 1'b1; step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_mode = ~step_mode;
      tick();
    end
    #1;
    n_cmp++; if (halted !== 1'b1 || count !== 32'd1 || ready !== 1'b0) begin
      n_fail++; $display("FAIL halt_stay halted=%b cnt=%0d ready=%b exp=1/1/0", halted, count, ready);
    end
    valid = 1'b0; step = 1'b0; step_mode = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    valid = 1'b1; op = 6'b000000; fn = 6'b100000;
    for (int i = 0; i < 20; i++) tick();
    valid = 1'b0;
    n_cmp++; if (s_count !== 4'hF) begin n_fail++; $display("FAIL sat_count got=%0d exp=15", s_count); end
    n_cmp++; if (count !== 32'd20) begin n_fail++; $display("FAIL sat_wide_count got=%0d exp=20", count); end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        valid = ($urandom_range(0, 3) != 0);
        if (c > 90 && $urandom_range(0, 19) == 0) op = 6'h3F;
        else begin
          op = 6'($urandom_range(0, 63));
          if (op == 6'h3F) op = 6'h3E;
        end
        fn = 6'($urandom_range(0, 63));
        stall = ($urandom_range(0, 6) == 0);
        flush = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
        step = ($urandom_range(0, 2) == 0);
        #1;
        n_cmp++; if (ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready blk=%0d cyc=%0d got=%b exp=%b", blk, c, ready, m_ready()); end
        tick();
        n_cmp++; if (ctrl !== m_ctrl || cvld !== m_vld) begin
          n_fail++; $display("FAIL rnd_ctrl blk=%0d cyc=%0d got=%h/%b exp=%h/%b", blk, c, ctrl, cvld, m_ctrl, m_vld);
        end
        n_cmp++; if (state !== 2'(m_state()) || halted !== (m_state() == 3)) begin
          n_fail++; $display("FAIL rnd_state blk=%0d cyc=%0d got=%0d/%b exp=%0d", blk, c, state, halted, m_state());
        end
        n_cmp++; if (count !== m_cnt || s_count !== 4'(m_scnt)) begin
          n_fail++; $display("FAIL rnd_count blk=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", blk, c, count, s_count, m_cnt, m_scnt);
        end
        n_cmp++; if (s_ctrl !== m_ctrl || s_cvld !== m_vld || s_state !== 2'(m_state()) || s_halted !== (m_state() == 3) || s_ready !== m_ready()) begin
          n_fail++; $display("FAIL rnd_sat_inst blk=%0d cyc=%0d got=%h/%b/%0d/%b/%b", blk, c, s_ctrl, s_cvld, s_state, s_halted, s_ready);
        end
      end
    end
    valid = 1'b0; stall = 1'b0; flush = 1'b0; step = 1'b0; step_mode = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lw();
    test_back_to_back();
    test_stall_flush();
    test_step();
    test_halt();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
